// File: rtl/gbuf_port_arbiter.sv
// gbuf_port_arbiter: shares one single-port global_buffer between the host
// command path (requester 0) and the TPU engine (requester 1). One transfer
// is granted per cycle, registered onto the buffer port, and read data is
// routed back to the issuing requester two cycles after its grant.
// Optional build macro: GBUF_ARB_CONFLICT_CNT_EN (denied-request counter).
module gbuf_port_arbiter #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 32,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 r0_req,
  input  logic                 r0_wr_en,
  input  logic [ADDR_BITS-1:0] r0_index,
  input  logic [DATA_BITS-1:0] r0_wdata,
  output logic                 r0_gnt,
  output logic                 r0_rvalid,
  output logic [DATA_BITS-1:0] r0_rdata,
  input  logic                 r1_req,
  input  logic                 r1_wr_en,
  input  logic [ADDR_BITS-1:0] r1_index,
  input  logic [DATA_BITS-1:0] r1_wdata,
  output logic                 r1_gnt,
  output logic                 r1_rvalid,
  output logic [DATA_BITS-1:0] r1_rdata,
  input  logic                 lock1,
  output logic                 mem_wr_en,
  output logic [ADDR_BITS-1:0] mem_index,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic [CNT_BITS-1:0]  conflict_cnt
);

  logic                 w_gnt0, w_gnt1, w_any_gnt;
  logic                 w_win_wr;
  logic [ADDR_BITS-1:0] w_win_index;
  logic [DATA_BITS-1:0] w_win_wdata;

  logic                 r_last_grant;
  logic                 r_mem_wr_en;
  logic [ADDR_BITS-1:0] r_mem_index;
  logic [DATA_BITS-1:0] r_mem_wdata;
  logic                 r_tag_vld;
  logic                 r_tag_id;
  logic                 r_r0_rvalid, r_r1_rvalid;
  logic [DATA_BITS-1:0] r_r0_rdata, r_r1_rdata;

  // Grant selection: lock1 reserves the port for the TPU, otherwise a lone
  // requester wins and a tie goes to whoever did not win last. No grants
  // while reset is high so nothing is accepted and then silently dropped.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset) begin
      if (lock1) begin
        w_gnt1 = r1_req;
      end else if (r0_req && r1_req) begin
        w_gnt0 = r_last_grant;
        w_gnt1 = ~r_last_grant;
      end else begin
        w_gnt0 = r0_req;
        w_gnt1 = r1_req;
      end
    end
  end

  assign w_any_gnt   = w_gnt0 | w_gnt1;
  assign w_win_wr    = w_gnt1 ? r1_wr_en : r0_wr_en;
  assign w_win_index = w_gnt1 ? r1_index : r0_index;
  assign w_win_wdata = w_gnt1 ? r1_wdata : r0_wdata;

  // Round-robin history; 1 after reset so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset)          r_last_grant <= 1'b1;
    else if (w_any_gnt) r_last_grant <= w_gnt1;
  end

  // Buffer port register: winner's command, or an idle (no-write) cycle
  // that keeps index/data stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_wr_en <= 1'b0;
      r_mem_index <= '0;
      r_mem_wdata <= '0;
    end else if (w_any_gnt) begin
      r_mem_wr_en <= w_win_wr;
      r_mem_index <= w_win_index;
      r_mem_wdata <= w_win_wdata;
    end else begin
      r_mem_wr_en <= 1'b0;
    end
  end

  // Read tag stage: marks that the port currently carries a read and whose.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_vld <= 1'b0;
      r_tag_id  <= 1'b0;
    end else begin
      r_tag_vld <= w_any_gnt & ~w_win_wr;
      r_tag_id  <= w_gnt1;
    end
  end

  // Response stage: the buffer drives data_out during the index cycle, so it
  // is captured at the end of that cycle and held until the next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_r0_rvalid <= 1'b0;
      r_r1_rvalid <= 1'b0;
      r_r0_rdata  <= '0;
      r_r1_rdata  <= '0;
    end else begin
      r_r0_rvalid <= r_tag_vld & ~r_tag_id;
      r_r1_rvalid <= r_tag_vld &  r_tag_id;
      if (r_tag_vld && !r_tag_id) r_r0_rdata <= mem_rdata;
      if (r_tag_vld &&  r_tag_id) r_r1_rdata <= mem_rdata;
    end
  end

  assign r0_gnt    = w_gnt0;
  assign r1_gnt    = w_gnt1;
  // A write already sitting on the port is killed in the reset cycle.
  assign mem_wr_en = r_mem_wr_en & ~reset;
  assign mem_index = r_mem_index;
  assign mem_wdata = r_mem_wdata;
  assign r0_rvalid = r_r0_rvalid & ~reset;
  assign r1_rvalid = r_r1_rvalid & ~reset;
  assign r0_rdata  = r_r0_rdata;
  assign r1_rdata  = r_r1_rdata;

`ifdef GBUF_ARB_CONFLICT_CNT_EN
  logic                w_denied;
  logic [CNT_BITS-1:0] r_conflict_cnt;

  // One count per cycle in which any requesting side was refused.
  assign w_denied = (r0_req & ~w_gnt0) | (r1_req & ~w_gnt1);

  // Saturating conflict counter.
  always_ff @(posedge clk) begin
    if (reset)
      r_conflict_cnt <= '0;
    else if (w_denied && (r_conflict_cnt != {CNT_BITS{1'b1}}))
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
  end

  assign conflict_cnt = r_conflict_cnt;
`else
  assign conflict_cnt = '0;
`endif

endmodule
